matrix_reader: RTL and testbench
================================

MATRIX_READER -- requirements
Module: matrix_reader

Interface
REQ-001 SHALL have parameter BLOCK_SIZE, default 1152, words per matrix slot.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, BRAM word width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 14, BRAM address width.
REQ-004 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports read_request in 1 (start pulse) and read_ready out 1 (high only in IDLE).
REQ-007 SHALL have port matrix_id  in  3  slot select, latched when read_request is accepted.
REQ-008 SHALL have outputs actual_rows 8, actual_cols 8, matrix_name 8x[0:7], and meta_valid 1 (held high once metadata is captured, until the next accepted request).
REQ-009 SHALL have ports data_out out DATA_WIDTH, data_valid out 1, and data_ready in 1; a beat transfers when data_valid && data_ready.
REQ-010 SHALL have outputs read_done 1 (one-cycle pulse) and read_error 1 (one-cycle pulse, coincident with read_done).
REQ-011 SHALL have outputs bram_rd_en 1 and bram_addr ADDR_WIDTH, plus input bram_dout DATA_WIDTH; the BRAM has registered output, so data is valid the cycle after bram_rd_en.

Function
REQ-012 SHALL take the slot base address from matrix_id, computed as matrix_id*BLOCK_SIZE.
REQ-013 SHALL use this slot layout:
- base+0 = {rows[31:24], cols[23:16], 16'd0}
- base+1 = name[0..3], MSB first
- base+2 = name[4..7], MSB first
- base+3 onward = elements, row-major
REQ-014 SHALL implement states IDLE, META_ROWS_COLS, META_NAME_HIGH, META_NAME_LOW, META_CAPTURE, STREAM, DONE.
REQ-015 SHALL move IDLE->META_ROWS_COLS on read_request; read_request outside IDLE SHALL be ignored.
REQ-016 SHALL issue the three META_* reads on consecutive cycles at base+0..2, capture each word one cycle later, and pass through META_CAPTURE while the final word lands.
REQ-017 SHALL assert meta_valid at the exit of META_CAPTURE.
REQ-018 SHALL compute total = rows*cols as 16 bits, with no truncation.
REQ-019 SHALL go META_CAPTURE->DONE with no data beats when total==0.
REQ-020 SHALL go META_CAPTURE->DONE with read_error pulsed when total > BLOCK_SIZE-3.
REQ-021 SHALL otherwise go META_CAPTURE->STREAM.
REQ-022 SHALL, in STREAM, issue element reads in ascending address from base+3, one per cycle maximum.
REQ-023 SHALL feed read data into a 2-entry output FIFO.
REQ-024 SHALL issue a read only when in-flight reads plus FIFO occupancy < 2 and issued < total, so no data is ever dropped.
REQ-025 SHALL drive data_valid from FIFO non-empty; data_out SHALL be the FIFO head.
REQ-026 SHALL hold data_out stable while data_valid && !data_ready.
REQ-027 SHALL allow an FIFO push and pop in the same cycle, leaving occupancy unchanged.
REQ-028 SHALL sustain 1 beat/cycle throughput with data_ready held high; first beat latency SHALL be 2 cycles after STREAM entry.
REQ-029 SHALL go STREAM->DONE when delivered==total.
REQ-030 SHALL go DONE->IDLE after one cycle, with read_done pulsed in DONE.
REQ-031 SHALL keep bram_rd_en low in IDLE and DONE; bram_addr value is don't-care when bram_rd_en is low.
REQ-032 SHALL size its counters to 16 bits, and SHALL not wrap the address past base+BLOCK_SIZE-1, which REQ-020 guarantees.

Reset
REQ-033 SHALL, on rst_n low (any cycle, including mid-stream), immediately enter IDLE.
REQ-034 SHALL reset these outputs to 0: read_done, read_error, meta_valid, data_valid, bram_rd_en, bram_addr, data_out, actual_rows, actual_cols, matrix_name.
REQ-035 SHALL, on reset, empty the FIFO, zero all counters, and discard in-flight reads.
REQ-036 SHALL reset read_ready to 1.

Structure
REQ-037 SHALL place the state enum and the META_WORDS=3 constant in shared package matrix_bram_pkg, reused by the writer side.
REQ-038 SHALL compute the slot base by instantiating the existing matrix_address_getter as its sub-module.
REQ-039 SHALL implement the 2-entry FIFO inline, not as a separate module.

Verification
REQ-040 Bench SHALL cover a 2x3 matrix in slot 1, elements 1..6, data_ready=1. Required: addresses 1152..1160 are read, rows=2, cols=3, name correct, beats 1..6 on consecutive cycles, then read_done.
REQ-041 Bench SHALL cover the same 2x3 case with data_ready toggling 1,0,0,1 repeating. Required: 6 beats in order, none duplicated or lost, data_out stable while stalled, no more than 2 outstanding reads.
REQ-042 Bench SHALL cover a 0x5 header. Required: meta_valid=1, zero beats, read_done one cycle after META_CAPTURE, read_error=0.
REQ-043 Bench SHALL cover a 40x40 header (1600 > 1149). Required: read_error and read_done pulse together, no element reads issued.
REQ-044 Bench SHALL cover rst_n low after the 3rd beat of a 4x4 read. Required: all outputs return to reset values, and a new request then reads the full 16 elements correctly.
REQ-045 Bench SHALL cover read_request pulsed during STREAM. Required: the pulse is ignored and the current transfer completes unaffected.

Source files
------------

// File: rtl/matrix_bram_pkg.sv
// -----------------------------------------------------------------------------
// matrix_bram_pkg
// Shared definitions for the matrix BRAM reader and writer.
//   mr_state_t  : reader FSM states (also exported on the debug state output)
//   META_WORDS  : header words at the start of every matrix slot
//   elem_count  : rows*cols widened to 16 bits so 255x255 does not truncate
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package matrix_bram_pkg;

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    META_ROWS_COLS = 3'd1,
    META_NAME_HIGH = 3'd2,
    META_NAME_LOW  = 3'd3,
    META_CAPTURE   = 3'd4,
    STREAM         = 3'd5,
    DONE           = 3'd6
  } mr_state_t;

  // Slot layout: base+0 rows/cols, base+1 name[0..3], base+2 name[4..7].
  localparam int META_WORDS = 3;

  function automatic logic [15:0] elem_count(input logic [7:0] rows,
                                             input logic [7:0] cols);
    return {8'd0, rows} * {8'd0, cols};
  endfunction

endpackage

// File: rtl/matrix_reader_if.sv
// -----------------------------------------------------------------------------
// matrix_reader_if
// Bundles every non-clock signal of matrix_reader.
//   Request side : read_request, matrix_id (in)  / read_ready (out)
//   Metadata     : actual_rows, actual_cols, matrix_name, meta_valid (out)
//   Stream       : data_out, data_valid (out) / data_ready (in)
//   Status       : read_done, read_error (out, one-cycle pulses)
//   BRAM port    : bram_rd_en, bram_addr (out) / bram_dout (in)
//   Debug        : dbg_state (out) current reader FSM state
//
// Handshake: a beat transfers on a rising edge where data_valid && data_ready
// are both high. Once data_valid rises it stays high, and data_out stays
// unchanged, until that beat transfers; data_ready may change freely.
// read_request is only acted on while read_ready is high (IDLE).
//
// Modports: slave = the reader, master = its client / BRAM side.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface matrix_reader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14
) ();
  import matrix_bram_pkg::*;

  logic                  read_request;
  logic                  read_ready;
  logic [2:0]            matrix_id;
  logic [7:0]            actual_rows;
  logic [7:0]            actual_cols;
  logic [0:7][7:0]       matrix_name;
  logic                  meta_valid;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  data_ready;
  logic                  read_done;
  logic                  read_error;
  logic                  bram_rd_en;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_dout;
  mr_state_t             dbg_state;

  modport slave (
    input  read_request, matrix_id, data_ready, bram_dout,
    output read_ready, actual_rows, actual_cols, matrix_name, meta_valid,
           data_out, data_valid, read_done, read_error, bram_rd_en, bram_addr,
           dbg_state
  );

  modport master (
    output read_request, matrix_id, data_ready, bram_dout,
    input  read_ready, actual_rows, actual_cols, matrix_name, meta_valid,
           data_out, data_valid, read_done, read_error, bram_rd_en, bram_addr,
           dbg_state
  );

endinterface

// File: rtl/matrix_address_getter.sv
// -----------------------------------------------------------------------------
// matrix_address_getter
// Maps a matrix slot number to the BRAM address of its first word.
//   i_matrix_id  in  3           slot number
//   o_base_addr  out ADDR_WIDTH  i_matrix_id * BLOCK_SIZE
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module matrix_address_getter #(
  parameter int BLOCK_SIZE = 1152,
  parameter int ADDR_WIDTH = 14
) (
  input  logic [2:0]            i_matrix_id,
  output logic [ADDR_WIDTH-1:0] o_base_addr
);

  logic [31:0] w_product;

  assign w_product   = {29'd0, i_matrix_id} * 32'(BLOCK_SIZE);
  assign o_base_addr = ADDR_WIDTH'(w_product);

endmodule

// File: rtl/matrix_reader.sv
// -----------------------------------------------------------------------------
// matrix_reader
// Reads one matrix slot out of a BRAM: three header words (dimensions and an
// 8-byte name), then streams rows*cols elements through a 2-entry output FIFO
// under valid/ready back-pressure.
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    matrix_reader_if.slave (request, metadata, stream, status, BRAM)
// The BRAM has a registered output: a word read in cycle N is on bram_dout in
// cycle N+1.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module matrix_reader
  import matrix_bram_pkg::*;
#(
  parameter int BLOCK_SIZE = 1152,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14
) (
  input  logic           clk,
  input  logic           rst_n,
  matrix_reader_if.slave bus
);

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  mr_state_t             r_state;
  mr_state_t             w_state_next;

  logic [2:0]            r_matrix_id;
  logic [ADDR_WIDTH-1:0] w_base_addr;

  logic [7:0]            r_rows;
  logic [7:0]            r_cols;
  logic [0:7][7:0]       r_name;
  logic                  r_meta_valid;
  logic                  r_error;

  logic [15:0]           w_total;
  logic                  w_too_big;
  logic [15:0]           r_issued;
  logic [15:0]           r_delivered;
  logic                  r_rd_pending;

  logic [DATA_WIDTH-1:0] r_fifo_mem [0:1];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_fifo_cnt;

  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;
  logic [2:0]            w_outstanding;
  logic                  w_elem_rd;
  logic                  w_last_pop;
  logic                  w_rd_en;
  logic [ADDR_WIDTH-1:0] w_addr;

  // ---------------------------------------------------------------------------
  // Slot base address
  // ---------------------------------------------------------------------------
  matrix_address_getter #(
    .BLOCK_SIZE (BLOCK_SIZE),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_getter (
    .i_matrix_id (r_matrix_id),
    .o_base_addr (w_base_addr)
  );

  // ---------------------------------------------------------------------------
  // Control terms
  // ---------------------------------------------------------------------------
  assign w_accept  = (r_state == IDLE) && bus.read_request;
  assign w_total   = elem_count(r_rows, r_cols);
  // A slot holds BLOCK_SIZE-META_WORDS elements; anything larger would run
  // into the next slot, so it is rejected before any element read is issued.
  assign w_too_big = int'({16'd0, w_total}) > (BLOCK_SIZE - META_WORDS);

  // The only data arriving in STREAM is the element read issued last cycle.
  assign w_push = r_rd_pending && (r_state == STREAM);
  assign w_pop  = (r_fifo_cnt != 2'd0) && bus.data_ready;

  // Words that will need a FIFO slot: the one landing now plus those already
  // stored, minus the head leaving this cycle. Keeping this below 2 before
  // issuing guarantees the FIFO can always accept what comes back, while still
  // allowing one read per cycle when the consumer keeps up.
  assign w_outstanding = {2'b00, r_rd_pending} + {1'b0, r_fifo_cnt}
                       - {2'b00, w_pop};

  assign w_elem_rd  = (r_state == STREAM) && (r_issued < w_total)
                   && (w_outstanding < 3'd2);
  assign w_last_pop = w_pop && ((r_delivered + 16'd1) == w_total);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and BRAM read port
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_rd_en      = 1'b0;
    w_addr       = '0;
    unique case (r_state)
      IDLE: begin
        if (bus.read_request) begin
          w_state_next = META_ROWS_COLS;
        end
      end
      META_ROWS_COLS: begin
        w_rd_en      = 1'b1;
        w_addr       = w_base_addr;
        w_state_next = META_NAME_HIGH;
      end
      META_NAME_HIGH: begin
        w_rd_en      = 1'b1;
        w_addr       = w_base_addr + ADDR_WIDTH'(1);
        w_state_next = META_NAME_LOW;
      end
      META_NAME_LOW: begin
        w_rd_en      = 1'b1;
        w_addr       = w_base_addr + ADDR_WIDTH'(2);
        w_state_next = META_CAPTURE;
      end
      META_CAPTURE: begin
        // rows/cols were captured two cycles ago, so the size is known here.
        if ((w_total == 16'd0) || w_too_big) begin
          w_state_next = DONE;
        end else begin
          w_state_next = STREAM;
        end
      end
      STREAM: begin
        w_rd_en = w_elem_rd;
        if (w_elem_rd) begin
          w_addr = w_base_addr + ADDR_WIDTH'(META_WORDS) + ADDR_WIDTH'(r_issued);
        end
        if (w_last_pop) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request latch, metadata capture and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_matrix_id  <= '0;
      r_rows       <= '0;
      r_cols       <= '0;
      r_name       <= '0;
      r_meta_valid <= 1'b0;
      r_error      <= 1'b0;
      r_issued     <= '0;
      r_delivered  <= '0;
      r_rd_pending <= 1'b0;
    end else begin
      r_rd_pending <= w_elem_rd;

      if (w_accept) begin
        r_matrix_id  <= bus.matrix_id;
        r_meta_valid <= 1'b0;
        r_error      <= 1'b0;
        r_issued     <= '0;
        r_delivered  <= '0;
      end

      // Each header word is on bram_dout one state after its read.
      case (r_state)
        META_NAME_HIGH: begin
          r_rows <= bus.bram_dout[DATA_WIDTH-1 -: 8];
          r_cols <= bus.bram_dout[DATA_WIDTH-9 -: 8];
        end
        META_NAME_LOW: begin
          for (int k = 0; k < 4; k++) begin
            r_name[k] <= bus.bram_dout[DATA_WIDTH-1-8*k -: 8];
          end
        end
        META_CAPTURE: begin
          for (int k = 0; k < 4; k++) begin
            r_name[k+4] <= bus.bram_dout[DATA_WIDTH-1-8*k -: 8];
          end
          r_meta_valid <= 1'b1;
          r_error      <= w_too_big;
        end
        default: begin
        end
      endcase

      if (w_elem_rd) begin
        r_issued <= r_issued + 16'd1;
      end
      if (w_pop) begin
        r_delivered <= r_delivered + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // 2-entry output FIFO (push and pop may coincide)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fifo_mem[0] <= '0;
      r_fifo_mem[1] <= '0;
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
      r_fifo_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_fifo_mem[r_wr_ptr] <= bus.bram_dout;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_fifo_cnt <= r_fifo_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.read_ready  = (r_state == IDLE);
  assign bus.actual_rows = r_rows;
  assign bus.actual_cols = r_cols;
  assign bus.matrix_name = r_name;
  assign bus.meta_valid  = r_meta_valid;
  assign bus.data_valid  = (r_fifo_cnt != 2'd0);
  assign bus.data_out    = r_fifo_mem[r_rd_ptr];
  assign bus.read_done   = (r_state == DONE);
  assign bus.read_error  = (r_state == DONE) && r_error;
  assign bus.bram_rd_en  = w_rd_en;
  assign bus.bram_addr   = w_addr;
  assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_matrix_reader.sv
`timescale 1ns/1ps

module tb_matrix_reader;
  import matrix_bram_pkg::*;

  localparam int BLOCK_SIZE = 1152;
  localparam int DW         = 32;
  localparam int AW         = 14;
  localparam int MAX_ELEMS  = BLOCK_SIZE - 3;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  matrix_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  matrix_reader #(
    .BLOCK_SIZE (BLOCK_SIZE),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------------------------------------------------------------------
  // BRAM model: registered read port
  // ---------------------------------------------------------------------------
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.bram_rd_en) bus.bram_dout <= mem[bus.bram_addr];
  end

  // ---------------------------------------------------------------------------
  // data_ready driver: 0 = always high, 1 = 1,0,0,1 repeating, 2 = random
  // ---------------------------------------------------------------------------
  int ready_mode = 0;
  int ready_idx  = 0;
  bit ready_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1:       bus.data_ready = ready_pat[ready_idx % 4];
      2:       bus.data_ready = 1'($urandom_range(0, 1));
      default: bus.data_ready = 1'b1;
    endcase
    ready_idx++;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state and reference model results
  // ---------------------------------------------------------------------------
  int errors = 0;
  int checks = 0;

  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  bit            exp_err;
  logic [7:0]    exp_rows;
  logic [7:0]    exp_cols;
  logic [63:0]   exp_name;
  int            exp_beats;
  int            cur_base;

  bit            active = 1'b0;
  bit            done_seen;
  bit            err_at_done;
  int            beats, elem_rd, n_reads;
  int            accept_cyc, done_cyc, first_beat_cyc, last_beat_cyc;
  int            first_addr, last_addr;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Compare process
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (active && rst_n) begin
      if (prev_stall) begin
        check("stall_valid", 64'(bus.data_valid), 64'd1);
        check("stall_data", 64'(bus.data_out), 64'(prev_data));
      end
      if (elem_rd > 0) check("outstanding_le2", 64'(elem_rd - beats <= 2), 64'd1);

      if (bus.data_valid && bus.data_ready) begin
        if (exp_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL extra_beat: got 0x%0h, expected no beat", bus.data_out);
        end else begin
          check("beat_data", 64'(bus.data_out), 64'(exp_q.pop_front()));
        end
        if (beats == 0) first_beat_cyc = cyc;
        last_beat_cyc = cyc;
        beats++;
      end

      if (bus.bram_rd_en) begin
        if (exp_addr_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL extra_read: got addr %0d, expected no read", bus.bram_addr);
        end else begin
          check("bram_addr", 64'(bus.bram_addr), 64'(exp_addr_q.pop_front()));
        end
        if (n_reads == 0) first_addr = int'(bus.bram_addr);
        last_addr = int'(bus.bram_addr);
        n_reads++;
        if (int'(bus.bram_addr) >= cur_base + 3) elem_rd++;
      end

      check("error_only_with_done", 64'(bus.read_error && !bus.read_done), 64'd0);

      if (bus.read_done) begin
        done_seen   = 1'b1;
        done_cyc    = cyc;
        err_at_done = bus.read_error;
        check("read_error", 64'(bus.read_error), 64'(exp_err));
        check("meta_valid", 64'(bus.meta_valid), 64'd1);
        check("rows", 64'(bus.actual_rows), 64'(exp_rows));
        check("cols", 64'(bus.actual_cols), 64'(exp_cols));
        check("name", 64'(bus.matrix_name), exp_name);
        check("beats_left", 64'(exp_q.size()), 64'd0);
        check("reads_left", 64'(exp_addr_q.size()), 64'd0);
      end
      prev_stall = bus.data_valid && !bus.data_ready;
      prev_data  = bus.data_out;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver / model tasks
  // ---------------------------------------------------------------------------
  task automatic load_slot(input int slot, input logic [7:0] rows, input logic [7:0] cols,
                           input logic [63:0] name, input bit seq);
    int base = slot * BLOCK_SIZE;
    int n    = int'(rows) * int'(cols);
    mem[base]     = {rows, cols, 16'd0};
    mem[base + 1] = name[63:32];
    mem[base + 2] = name[31:0];
    if (n > MAX_ELEMS) n = 0;
    for (int i = 0; i < n; i++) mem[base + 3 + i] = seq ? DW'(i + 1) : $urandom;
  endtask

  // Expected behaviour derived from the slot contents alone.
  task automatic expect_read(input int slot);
    int base  = slot * BLOCK_SIZE;
    int total;
    exp_rows  = mem[base][31:24];
    exp_cols  = mem[base][23:16];
    exp_name  = {mem[base + 1], mem[base + 2]};
    total     = int'(exp_rows) * int'(exp_cols);
    exp_err   = total > MAX_ELEMS;
    exp_beats = exp_err ? 0 : total;
    cur_base  = base;
    exp_q.delete();
    exp_addr_q.delete();
    for (int i = 0; i < 3; i++) exp_addr_q.push_back(AW'(base + i));
    for (int i = 0; i < exp_beats; i++) begin
      exp_addr_q.push_back(AW'(base + 3 + i));
      exp_q.push_back(mem[base + 3 + i]);
    end
  endtask

  task automatic start_read(input int slot);
    int t = 0;
    @(negedge clk);
    while (!bus.read_ready && t < 50) begin @(negedge clk); t++; end
    check("ready_before_request", 64'(bus.read_ready), 64'd1);
    @(posedge clk); #1;
    bus.matrix_id    = 3'(slot);
    bus.read_request = 1'b1;
    @(posedge clk); #1;
    bus.read_request = 1'b0;
    bus.matrix_id    = 3'($urandom_range(0, 7));
    accept_cyc       = cyc;
    check("ready_low_after_accept", 64'(bus.read_ready), 64'd0);
    check("meta_cleared_on_accept", 64'(bus.meta_valid), 64'd0);
  endtask

  task automatic begin_case(input int slot, input int mode);
    expect_read(slot);
    ready_mode = mode;
    ready_idx  = 0;
    beats      = 0;
    elem_rd    = 0;
    n_reads    = 0;
    done_seen  = 1'b0;
    active     = 1'b1;
    start_read(slot);
  endtask

  task automatic finish_case(input int exp_lat, input int exp_first);
    int t = 0;
    while (!done_seen && t < 3000) begin @(negedge clk); #1; t++; end
    check("done_within_budget", 64'(done_seen), 64'd1);
    if (exp_lat >= 0) check("done_latency", 64'(done_cyc - accept_cyc), 64'(exp_lat));
    if (exp_first >= 0) check("first_beat_latency", 64'(first_beat_cyc - accept_cyc), 64'(exp_first));
    check("beat_total", 64'(beats), 64'(exp_beats));
    @(negedge clk); #1;
    check("done_one_cycle", 64'(bus.read_done), 64'd0);
    check("ready_after_done", 64'(bus.read_ready), 64'd1);
  endtask

  task automatic wait_beats(input int n);
    int t = 0;
    while (beats < n && t < 500) begin @(negedge clk); #1; t++; end
    check("reached_beat", 64'(beats >= n), 64'd1);
  endtask

  task automatic check_reset_outputs();
    check("rst_read_done", 64'(bus.read_done), 64'd0);
    check("rst_read_error", 64'(bus.read_error), 64'd0);
    check("rst_meta_valid", 64'(bus.meta_valid), 64'd0);
    check("rst_data_valid", 64'(bus.data_valid), 64'd0);
    check("rst_bram_rd_en", 64'(bus.bram_rd_en), 64'd0);
    check("rst_bram_addr", 64'(bus.bram_addr), 64'd0);
    check("rst_data_out", 64'(bus.data_out), 64'd0);
    check("rst_rows", 64'(bus.actual_rows), 64'd0);
    check("rst_cols", 64'(bus.actual_cols), 64'd0);
    check("rst_name", 64'(bus.matrix_name), 64'd0);
    check("rst_read_ready", 64'(bus.read_ready), 64'd1);
    check("rst_state", 64'(bus.dbg_state), 64'(IDLE));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    bus.read_request = 1'b0;
    bus.matrix_id    = 3'd0;
    #3;
    check_reset_outputs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 2x3 in slot 1, elements 1..6, consumer always ready.
    load_slot(1, 8'd2, 8'd3, "MATRIX_A", 1'b1);
    begin_case(1, 0);
    finish_case(12, 6);
    check("lit_first_addr", 64'(first_addr), 64'd1152);
    check("lit_last_addr", 64'(last_addr), 64'd1160);
    check("lit_rows", 64'(bus.actual_rows), 64'd2);
    check("lit_cols", 64'(bus.actual_cols), 64'd3);
    check("lit_name", 64'(bus.matrix_name), "MATRIX_A");
    check("lit_back_to_back", 64'(last_beat_cyc - first_beat_cyc), 64'd5);

    // Same matrix, data_ready 1,0,0,1 repeating.
    begin_case(1, 1);
    finish_case(-1, -1);

    // 0x5 header: no beats, no error, done one cycle after META_CAPTURE.
    load_slot(3, 8'd0, 8'd5, "ZERO_ROW", 1'b0);
    begin_case(3, 0);
    finish_case(4, -1);
    check("lit_zero_no_error", 64'(err_at_done), 64'd0);
    check("lit_zero_reads", 64'(n_reads), 64'd3);

    // 40x40 header: too large, error with done, no element reads.
    load_slot(4, 8'd40, 8'd40, "TOO_BIG!", 1'b0);
    begin_case(4, 0);
    finish_case(4, -1);
    check("lit_big_error", 64'(err_at_done), 64'd1);
    check("lit_big_elem_reads", 64'(elem_rd), 64'd0);

    // Largest allowed vs just over the limit.
    load_slot(7, 8'd31, 8'd37, "EDGE_OK_", 1'b0);
    begin_case(7, 0);
    finish_case(-1, -1);
    load_slot(6, 8'd25, 8'd46, "EDGE_BAD", 1'b0);
    begin_case(6, 2);
    finish_case(4, -1);

    // Reset after the 3rd beat of a 4x4 read, then a clean re-read.
    load_slot(2, 8'd4, 8'd4, "FOUR_BY4", 1'b0);
    begin_case(2, 0);
    wait_beats(3);
    @(posedge clk); #2;
    rst_n  = 1'b0;
    active = 1'b0;
    #1;
    check_reset_outputs();
    exp_q.delete();
    exp_addr_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    begin_case(2, 2);
    finish_case(-1, -1);
    check("lit_reread_beats", 64'(beats), 64'd16);

    // read_request pulsed while streaming must be ignored.
    load_slot(5, 8'd5, 8'd7, "INJECTED", 1'b0);
    load_slot(0, 8'd3, 8'd3, "OTHERSLT", 1'b0);
    begin_case(5, 2);
    wait_beats(2);
    @(posedge clk); #1;
    bus.matrix_id    = 3'd0;
    bus.read_request = 1'b1;
    @(posedge clk); #1;
    bus.read_request = 1'b0;
    finish_case(-1, -1);
    repeat (5) @(negedge clk);
    #1;
    check("inject_still_idle", 64'(bus.read_ready), 64'd1);
    check("inject_read_count", 64'(n_reads), 64'd38);

    // Randomized slots, shapes and back-pressure.
    for (int k = 0; k < 6; k++) begin
      int slot = $urandom_range(0, 7);
      load_slot(slot, 8'($urandom_range(1, 20)), 8'($urandom_range(1, 20)),
                {$urandom, $urandom}, 1'b0);
      begin_case(slot, $urandom_range(0, 2));
      finish_case(-1, -1);
    end

    active = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
